// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: drives latch hold/squash controls,
// the PC enable and the branch redirect, and keeps saturating stall/flush event counters.
module pipeline_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             stg_clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_rd_memory,
    input  logic             ex_mispredict,
    input  logic             mem_busy,
    output logic             pc_ena,
    output logic             fd_ena,
    output logic             fd_x,
    output logic             dl_ena,
    output logic             dl_x,
    output logic             em_ena,
    output logic             em_x,
    output logic             mw_ena,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {StRun, StStall} state_e;

    // Reload value covers the bubbles after the first one, which the RUN cycle itself inserts.
    localparam logic [3:0] StallReload =
        (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, flush_count_q;
    logic             stall_inc, flush_inc;
    logic             rs1_hit, rs2_hit, hz;

    assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd);
    assign hz      = ex_valid & ex_rd_memory & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        pc_ena    = 1'b1;
        fd_ena    = 1'b1;
        fd_x      = 1'b0;
        dl_ena    = 1'b1;
        dl_x      = 1'b0;
        em_ena    = 1'b1;
        em_x      = 1'b0;
        mw_ena    = 1'b1;
        redirect  = 1'b0;

        if (mem_busy) begin
            pc_ena = 1'b0;
            fd_ena = 1'b0;
            dl_ena = 1'b0;
            em_ena = 1'b0;
            mw_ena = 1'b0;
        end else if (ex_mispredict) begin
            redirect  = 1'b1;
            fd_x      = 1'b1;
            dl_x      = 1'b1;
            state_d   = StRun;
            flush_inc = 1'b1;
        end else if ((state_q == StRun && hz) || state_q == StStall) begin
            // Hold PC and IF/ID, feed a bubble into execute while older stages drain.
            pc_ena    = 1'b0;
            fd_ena    = 1'b0;
            dl_x      = 1'b1;
            stall_inc = 1'b1;
            if (state_q == StRun) begin
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = StStall;
                    cnt_d   = StallReload;
                end
            end else if (cnt_q == 4'd0) begin
                state_d = StRun;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end

        if (!reset) begin
            pc_ena   = 1'b0;
            fd_ena   = 1'b0;
            fd_x     = 1'b0;
            dl_ena   = 1'b0;
            dl_x     = 1'b0;
            em_ena   = 1'b0;
            em_x     = 1'b0;
            mw_ena   = 1'b0;
            redirect = 1'b0;
        end
    end

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_inc && stall_count_q != '1) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (flush_inc && flush_count_q != '1) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances (1-bubble/32-bit and 3-bubble/4-bit counters)
// share stimulus; expected outputs go through a scoreboard queue checked each cycle.
module tb_pipeline_ctrl;

    // {pc_ena, fd_ena, fd_x, dl_ena, dl_x, em_ena, em_x, mw_ena, redirect}
    localparam logic [8:0] Zero = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] RunV = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] StlV = 9'b0_0_0_1_1_1_0_1_0;
    localparam logic [8:0] FlsV = 9'b1_1_1_1_1_1_0_1_1;

    logic       stg_clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_valid, ex_rd_memory, ex_mispredict, mem_busy;

    logic        pc_a, fde_a, fdx_a, dle_a, dlx_a, eme_a, emx_a, mwe_a, red_a;
    logic        pc_b, fde_b, fdx_b, dle_b, dlx_b, eme_b, emx_b, mwe_b, red_b;
    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;
    logic [8:0]  ctl_a, ctl_b;

    assign ctl_a = {pc_a, fde_a, fdx_a, dle_a, dlx_a, eme_a, emx_a, mwe_a, red_a};
    assign ctl_b = {pc_b, fde_b, fdx_b, dle_b, dlx_b, eme_b, emx_b, mwe_b, red_b};

    always #5 stg_clk = ~stg_clk;

    pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
        .stg_clk(stg_clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_mispredict(ex_mispredict),
        .mem_busy(mem_busy), .pc_ena(pc_a), .fd_ena(fde_a), .fd_x(fdx_a), .dl_ena(dle_a),
        .dl_x(dlx_a), .em_ena(eme_a), .em_x(emx_a), .mw_ena(mwe_a), .redirect(red_a),
        .stall_count(stall_a), .flush_count(flush_a)
    );

    pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .stg_clk(stg_clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_rd_memory(ex_rd_memory), .ex_mispredict(ex_mispredict),
        .mem_busy(mem_busy), .pc_ena(pc_b), .fd_ena(fde_b), .fd_x(fdx_b), .dl_ena(dle_b),
        .dl_x(dlx_b), .em_ena(eme_b), .em_x(emx_b), .mw_ena(mwe_b), .redirect(red_b),
        .stall_count(stall_b), .flush_count(flush_b)
    );

    typedef struct {
        string       tag;
        bit          is_b;
        logic [8:0]  ctl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push(input string tag, input logic [8:0] ca, input int unsigned sa,
                        input int unsigned fa, input logic [8:0] cb, input int unsigned sb,
                        input int unsigned fb);
        sb_q.push_back('{tag: tag, is_b: 1'b0, ctl: ca, stall: sa, flush: fa});
        sb_q.push_back('{tag: tag, is_b: 1'b1, ctl: cb, stall: sb, flush: fb});
    endtask

    task automatic check_cycle();
        exp_t        e;
        logic [8:0]  o_ctl;
        logic [31:0] o_stall, o_flush;
        @(negedge stg_clk);
        while (sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            o_ctl   = e.is_b ? ctl_b : ctl_a;
            o_stall = e.is_b ? {28'd0, stall_b} : stall_a;
            o_flush = e.is_b ? {28'd0, flush_b} : flush_a;
            n_total++;
            assert (o_ctl === e.ctl) n_pass++;
            else $error("FAIL %s/%s ctl: got %b want %b", e.tag, e.is_b ? "b" : "a", o_ctl, e.ctl);
            n_total++;
            assert (o_stall === e.stall) n_pass++;
            else $error("FAIL %s/%s stall_count: got %0d want %0d", e.tag,
                        e.is_b ? "b" : "a", o_stall, e.stall);
            n_total++;
            assert (o_flush === e.flush) n_pass++;
            else $error("FAIL %s/%s flush_count: got %0d want %0d", e.tag,
                        e.is_b ? "b" : "a", o_flush, e.flush);
        end
    endtask

    task automatic step();
        @(posedge stg_clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [8:0] ca, input int unsigned sa,
                       input int unsigned fa, input logic [8:0] cb, input int unsigned sb,
                       input int unsigned fb);
        push(tag, ca, sa, fa, cb, sb, fb);
        check_cycle();
        step();
    endtask

    initial begin
        reset         = 1'b0;
        ex_valid      = 1'b1;
        ex_rd_memory  = 1'b1;
        ex_rd         = 5'd5;
        id_rs2        = 5'd5;
        id_rs2_used   = 1'b1;
        id_rs1        = 5'd0;
        id_rs1_used   = 1'b0;
        ex_mispredict = 1'b0;
        mem_busy      = 1'b0;

        repeat (3) cyc("reset", Zero, 0, 0, Zero, 0, 0);
        reset    = 1'b1;
        ex_valid = 1'b0;
        cyc("release", RunV, 0, 0, RunV, 0, 0);

        // Load-use via rs2; the load leaves execute after the first edge.
        ex_valid = 1'b1;
        cyc("lu_hz", StlV, 0, 0, StlV, 0, 0);
        ex_valid = 1'b0;
        cyc("lu_2", RunV, 1, 0, StlV, 1, 0);
        cyc("lu_3", RunV, 1, 0, StlV, 2, 0);
        cyc("lu_end", RunV, 1, 0, RunV, 3, 0);

        ex_valid = 1'b1;
        ex_rd    = 5'd0;
        id_rs2   = 5'd0;
        cyc("x0", RunV, 1, 0, RunV, 3, 0);
        cyc("x0_hold", RunV, 1, 0, RunV, 3, 0);
        ex_rd  = 5'd7;
        id_rs1 = 5'd7;
        cyc("rs1_unused", RunV, 1, 0, RunV, 3, 0);
        id_rs1_used  = 1'b1;
        ex_rd_memory = 1'b0;
        cyc("not_load", RunV, 1, 0, RunV, 3, 0);

        // Load-use via rs1, mispredict in the second STALL-state cycle.
        ex_rd_memory = 1'b1;
        id_rs2_used  = 1'b0;
        cyc("mp_hz", StlV, 1, 0, StlV, 3, 0);
        ex_valid = 1'b0;
        cyc("mp_st1", RunV, 2, 0, StlV, 4, 0);
        ex_mispredict = 1'b1;
        cyc("mp_flush", FlsV, 2, 0, FlsV, 5, 0);
        ex_mispredict = 1'b0;
        cyc("mp_after", RunV, 2, 1, RunV, 5, 1);

        // Freeze in STALL with cnt = 1 while a mispredict is pending.
        ex_valid = 1'b1;
        cyc("mb_hz", StlV, 2, 1, StlV, 5, 1);
        ex_valid      = 1'b0;
        mem_busy      = 1'b1;
        ex_mispredict = 1'b1;
        repeat (4) cyc("mb_freeze", Zero, 3, 1, Zero, 6, 1);
        mem_busy = 1'b0;
        cyc("mb_take", FlsV, 3, 1, FlsV, 6, 1);
        ex_mispredict = 1'b0;
        cyc("mb_after", RunV, 3, 2, RunV, 6, 2);

        ex_valid      = 1'b1;
        ex_mispredict = 1'b1;
        cyc("mp_and_hz", FlsV, 3, 2, FlsV, 6, 2);
        ex_valid      = 1'b0;
        ex_mispredict = 1'b0;
        cyc("mp_and_hz_after", RunV, 3, 3, RunV, 6, 3);

        // Held hazard: the 4-bit counter must stop at 15.
        ex_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc("sat", StlV, 3 + k, 3, StlV, (6 + k > 15) ? 15 : 6 + k, 3);
        end
        ex_valid = 1'b0;
        cyc("sat_tail", RunV, 23, 3, StlV, 15, 3);
        cyc("sat_run", RunV, 23, 3, RunV, 15, 3);

        // Asynchronous reset while dut_b sits in STALL.
        ex_valid = 1'b1;
        push("pre_rst", StlV, 23, 3, StlV, 15, 3);
        check_cycle();
        step();
        ex_valid = 1'b0;
        #2;
        reset = 1'b0;
        push("mid_rst", Zero, 0, 0, Zero, 0, 0);
        check_cycle();
        step();
        reset = 1'b1;
        cyc("rst_rel", RunV, 0, 0, RunV, 0, 0);
        cyc("rst_run", RunV, 0, 0, RunV, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the 5-stage RISC-V pipeline. It drives the `*_ena` (hold) and `*_x` (squash-to-bubble) controls of the four stage latches: fetch/decode, decode/execute, execute/memory and memory/writeback. It also drives the PC-register enable. Decisions combine three inputs: a registered stall FSM, the decode-stage operand usage, and the execute-stage state held in the decode latch. It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15)
- CNT_W, 32, width of the performance counters

Ports:
- stg_clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- id_rs1, id_rs2  input  5 each  source registers of the instruction currently in decode
- id_rs1_used, id_rs2_used  input  1 each  operand-used flags from the decoder
- ex_valid  input  1  decode-latch `valid_out`
- ex_rd  input  5  decode-latch `rd_out`
- ex_rd_memory  input  1  decode-latch `rd_memory_out` (load in execute)
- ex_mispredict  input  1  branch in execute resolved against its prediction
- mem_busy  input  1  data memory not ready; the whole pipeline must freeze
- pc_ena  output  1  PC register update enable
- fd_ena, fd_x  output  1 each  fetch/decode latch enable and squash
- dl_ena, dl_x  output  1 each  decode/execute latch enable and squash
- em_ena, em_x  output  1 each  execute/memory latch enable and squash
- mw_ena  output  1  memory/writeback latch enable
- redirect  output  1  PC mux selects the corrected branch target
- stall_count  output  CNT_W  cycles spent in load-use stall
- flush_count  output  CNT_W  mispredict flushes taken

## Operation
- State register has two states: RUN and STALL. It has a 4-bit down-counter `cnt`.
- Hazard term: `hz = ex_valid & ex_rd_memory & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))`.
- Outputs are combinational from state and inputs. Priority is highest first:
  1. **mem_busy = 1**: all `*_ena` = 0, all `*_x` = 0, redirect = 0. State, `cnt` and both counters hold.
  2. **ex_mispredict = 1**: redirect = 1, fd_x = 1, dl_x = 1. All `*_ena` = 1, em_x = 0. Next state is RUN (this cancels any stall). flush_count increments.
  3. **RUN & hz**: pc_ena = 0, fd_ena = 0, dl_x = 1. em_ena, mw_ena and dl_ena stay 1. stall_count increments.
     - If LOAD_STALL_CYCLES > 1: next state is STALL and `cnt` loads LOAD_STALL_CYCLES − 2.
  4. **STALL**: same outputs as case 3. stall_count increments. If `cnt` = 0, next state is RUN; otherwise `cnt` decrements.
  5. **Default (RUN, no hazard)**: all `*_ena` = 1, all `*_x` = 0, redirect = 0.
- Counters saturate at all-ones and do not wrap.
- em_x is reserved. It is constant 0 in this revision.

## Timing
- Reset (reset = 0, asynchronous): state = RUN, `cnt` = 0, stall_count = 0, flush_count = 0. While reset is low, every output is 0, including all enables.
- Reset release: normal operation starts at the first rising edge of stg_clk.
- Reset mid-stall: the stall is abandoned and the block is in RUN immediately after release.
- Stall latency: a load-use hazard is seen in the same cycle. Total bubbles into execute = LOAD_STALL_CYCLES. The dependent instruction enters execute LOAD_STALL_CYCLES + 1 edges after the load entered execute.
- Mispredict: a single-cycle response. Two instructions (IF/ID and ID/EX) are squashed at the next edge.
- Simultaneous events:
  - Mispredict together with a hazard: the mispredict wins and no stall cycle is counted.
  - mem_busy together with anything: the freeze wins and the pending event is re-evaluated when busy drops.
- Latch contract: `x` has priority over `ena` inside each stage latch, so dl_x = 1 with dl_ena = 1 is legal and yields a bubble.
- Rule: rd = x0 never causes a stall.

## Test plan
- **Reset**: hold reset = 0 for 3 cycles with hz stimulus applied.
  - Required: all outputs 0; after release with no hazard, pc_ena = fd_ena = dl_ena = em_ena = mw_ena = 1 and counters = 0.
- **Load-use, LOAD_STALL_CYCLES = 1**: ex_valid = 1, ex_rd_memory = 1, ex_rd = 5, id_rs2 = 5, id_rs2_used = 1.
  - Required: exactly 1 cycle with pc_ena = 0, fd_ena = 0, dl_x = 1; stall_count = 1.
  - Repeat with ex_rd = 0: no stall.
- **Load-use, LOAD_STALL_CYCLES = 3**: same stimulus, with ex_valid = 0 after the first edge.
  - Required: dl_x = 1 for 3 consecutive cycles, then RUN; stall_count = 3.
- **Mispredict during STALL** (second stall cycle): pulse ex_mispredict.
  - Required: redirect = 1, fd_x = dl_x = 1, pc_ena = 1; next cycle in RUN; flush_count = 1; stall_count = 2.
- **mem_busy freeze**: assert for 4 cycles while in STALL with cnt = 1, plus ex_mispredict = 1.
  - Required: all enables 0 and counters unchanged for 4 cycles. After release the mispredict is taken and flush_count = 1.
- **Saturation**: with CNT_W = 4, hold a hazard for 20 cycles.
  - Required: stall_count stops at 15.
